// File: rtl/mul_rs_pkg.sv
// mul_rs_pkg: shared types and default widths for the multiplier reservation station
package mul_rs_pkg;
  localparam int XLEN_D = 32;
  localparam int TAG_W_D = 4;
  typedef enum logic [1:0] {EX_IDLE, EX_BUSY, EX_WB} ex_state_e;
  typedef struct packed {
    logic               valid;
    logic [TAG_W_D-1:0] tag;
    logic [XLEN_D-1:0]  vj;
    logic [XLEN_D-1:0]  vk;
    logic [TAG_W_D-1:0] qj;
    logic [TAG_W_D-1:0] qk;
    logic               j_rdy;
    logic               k_rdy;
  } rs_entry_t;
endpackage

// File: rtl/mul_rs_prio_sel.sv
// rs_prio_sel: lowest-index one-hot picker with found flag
module rs_prio_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         found
);
  assign gnt = req & (-req);
  assign found = |req;
endmodule

// File: rtl/mul_rs.sv
// mul_rs: reservation station feeding the 6-cycle multiplier and the CDB.
// MUL_RS_BYPASS_EN: capture a same-cycle CDB broadcast at allocation instead of stalling issue.
module mul_rs
  import mul_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = TAG_W_D,
  parameter int XLEN  = XLEN_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [XLEN-1:0]            issue_vj,
  input  logic [XLEN-1:0]            issue_vk,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic                       issue_j_rdy,
  input  logic                       issue_k_rdy,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       mul_ena,
  output logic [XLEN-1:0]            mul_a,
  output logic [XLEN-1:0]            mul_b,
  input  logic [XLEN-1:0]            mul_result,
  input  logic                       mul_valid,
  output logic                       mul_flush,
  output logic                       wb_req,
  input  logic                       wb_gnt,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [XLEN-1:0]            wb_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  rs_entry_t rs [DEPTH];
  rs_entry_t new_e, sel_e;
  ex_state_e state;
  logic [DEPTH-1:0] free, rdy, alloc_oh, sel_oh;
  logic free_found, sel_found, alloc, dispatch, first;
  logic [TAG_W-1:0] cur_tag;
  rs_prio_sel #(.N(DEPTH)) u_alloc (.req(free), .gnt(alloc_oh), .found(free_found));
  rs_prio_sel #(.N(DEPTH)) u_sel (.req(rdy), .gnt(sel_oh), .found(sel_found));
`ifdef MUL_RS_BYPASS_EN
  assign issue_ready = free_found && !flush;
`else
  assign issue_ready = free_found && !flush && !cdb_valid;
`endif
  assign alloc = issue_valid && issue_ready;
  assign dispatch = sel_found && state == EX_IDLE && !flush;
  always_comb begin
    free = '0;
    rdy = '0;
    sel_e = '0;
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free[i] = !rs[i].valid;
      rdy[i] = rs[i].valid && rs[i].j_rdy && rs[i].k_rdy;
      occupancy = occupancy + OW'(rs[i].valid);
      if (sel_oh[i]) sel_e = rs[i];
    end
  end
  always_comb begin
    new_e = '{valid: 1'b1, tag: issue_tag, vj: issue_vj, vk: issue_vk, qj: issue_qj,
              qk: issue_qk, j_rdy: issue_j_rdy, k_rdy: issue_k_rdy};
`ifdef MUL_RS_BYPASS_EN
    if (!issue_j_rdy && cdb_valid && issue_qj == cdb_tag) begin
      new_e.vj = cdb_data;
      new_e.j_rdy = 1'b1;
    end
    if (!issue_k_rdy && cdb_valid && issue_qk == cdb_tag) begin
      new_e.vk = cdb_data;
      new_e.k_rdy = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rs[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) rs[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alloc && alloc_oh[i]) rs[i] <= new_e;
        else if (dispatch && sel_oh[i]) rs[i].valid <= 1'b0;
        else if (rs[i].valid) begin
          if (!rs[i].j_rdy && cdb_valid && rs[i].qj == cdb_tag) begin
            rs[i].vj <= cdb_data;
            rs[i].j_rdy <= 1'b1;
          end
          if (!rs[i].k_rdy && cdb_valid && rs[i].qk == cdb_tag) begin
            rs[i].vk <= cdb_data;
            rs[i].k_rdy <= 1'b1;
          end
        end
    end
  // first blanks the stale mul_valid left over from the previous op
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EX_IDLE;
      first <= 1'b0;
      mul_ena <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      cur_tag <= '0;
      wb_req <= 1'b0;
      wb_tag <= '0;
      wb_data <= '0;
      mul_flush <= 1'b0;
    end else begin
      mul_flush <= flush;
      first <= 1'b0;
      if (flush) begin
        state <= EX_IDLE;
        mul_ena <= 1'b0;
        wb_req <= 1'b0;
      end else
        case (state)
          EX_IDLE:
            if (dispatch) begin
              mul_a <= sel_e.vj;
              mul_b <= sel_e.vk;
              cur_tag <= sel_e.tag;
              mul_ena <= 1'b1;
              first <= 1'b1;
              state <= EX_BUSY;
            end
          EX_BUSY:
            if (!first && mul_valid) begin
              wb_data <= mul_result;
              wb_tag <= cur_tag;
              mul_ena <= 1'b0;
              wb_req <= 1'b1;
              state <= EX_WB;
            end
          EX_WB:
            if (wb_gnt) begin
              wb_req <= 1'b0;
              state <= EX_IDLE;
            end
          default: state <= EX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mul_rs.sv
// tb_mul_rs: directed vectors for mul_rs against a 6-cycle multiplier model
module tb_mul_rs;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic issue_valid = 1'b0, issue_ready;
  logic [3:0] issue_tag = '0, issue_qj = '0, issue_qk = '0, cdb_tag = '0, wb_tag;
  logic [31:0] issue_vj = '0, issue_vk = '0, cdb_data = '0;
  logic issue_j_rdy = 1'b0, issue_k_rdy = 1'b0, cdb_valid = 1'b0;
  logic mul_ena, mul_valid, mul_flush, wb_req, wb_gnt = 1'b0;
  logic [31:0] mul_a, mul_b, mul_result, wb_data;
  logic [2:0] occupancy;
  logic [2:0] mcnt;
  logic ena_d;
  int n_tests = 0, n_fail = 0, lat;

  always #5 clk = ~clk;

  mul_rs dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag(issue_tag), .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj),
    .issue_qk(issue_qk), .issue_j_rdy(issue_j_rdy), .issue_k_rdy(issue_k_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .mul_ena(mul_ena),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_valid(mul_valid),
    .mul_flush(mul_flush), .wb_req(wb_req), .wb_gnt(wb_gnt), .wb_tag(wb_tag),
    .wb_data(wb_data), .occupancy(occupancy)
  );

  // multiplier model: restarts on enable rise, holds count while disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcnt <= '0;
      ena_d <= 1'b0;
    end else begin
      ena_d <= mul_ena;
      if (mul_flush) mcnt <= '0;
      else if (mul_ena && !ena_d) mcnt <= 3'd1;
      else if (mul_ena && mcnt < 3'd6) mcnt <= mcnt + 3'd1;
    end
  assign mul_valid = mcnt == 3'd6;
  assign mul_result = mul_a * mul_b;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic [31:0] p;
  } vec_t;
  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] tag, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic [3:0] qk, input logic jr, input logic kr);
    issue_valid = 1'b1; issue_tag = tag; issue_vj = vj; issue_vk = vk;
    issue_qj = qj; issue_qk = qk; issue_j_rdy = jr; issue_k_rdy = kr;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_wb(output int l);
    l = 0;
    while (!wb_req && l < 50) begin
      step();
      l++;
    end
  endtask

  task automatic grant();
    wb_gnt = 1'b1;
    step();
    wb_gnt = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'd3, 32'd2, 4'd3, 32'd6};
    tbl[1] = '{32'd0, 32'd123, 4'd2, 32'd0};
    tbl[2] = '{32'hFFFF_FFFF, 32'd2, 4'd15, 32'hFFFF_FFFE};
    tbl[3] = '{32'h0001_0000, 32'h0001_0000, 4'd0, 32'd0};
    tbl[4] = '{32'd1000, 32'd1000, 4'd5, 32'd1000000};
    #1;
    check("rst_mul_ena", 32'(mul_ena), 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_wb_req", 32'(wb_req), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_occ", 32'(occupancy), 0);
    step();
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(issue_ready), 1);
    check("mul_flush_idle", 32'(mul_flush), 0);

    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].tag, tbl[i].a, tbl[i].b, 4'd0, 4'd0, 1'b1, 1'b1);
      check("occ_alloc", 32'(occupancy), 1);
      step();
      check("dispatch_ena", 32'(mul_ena), 1);
      check("dispatch_a", mul_a, tbl[i].a);
      check("dispatch_b", mul_b, tbl[i].b);
      check("occ_dispatch", 32'(occupancy), 0);
      wait_wb(lat);
      check("latency", 32'(lat), 7);
      check("wb_tag", 32'(wb_tag), 32'(tbl[i].tag));
      check("wb_data", wb_data, tbl[i].p);
      check("ena_off_at_wb", 32'(mul_ena), 0);
      if (i == 0)
        for (int h = 0; h < 3; h++) begin
          step();
          check("wb_hold_req", 32'(wb_req), 1);
          check("wb_hold_data", wb_data, 32'd6);
        end
      grant();
      check("wb_drop", 32'(wb_req), 0);
    end

    // operand wakeup from the CDB
    issue(4'd1, 32'd0, 32'd5, 4'd7, 4'd0, 1'b0, 1'b1);
    step();
    check("no_dispatch_unready", 32'(mul_ena), 0);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'd4;
    step();
    cdb_valid = 1'b0;
    step();
    check("wake_dispatch", 32'(mul_ena), 1);
    wait_wb(lat);
    check("wake_wb_req", 32'(wb_req), 1);
    check("wake_data", wb_data, 32'd20);
    check("wake_tag", 32'(wb_tag), 1);
    grant();

    // fill, then wake entries 0 and 2 on one broadcast
    issue(4'd4, 32'd0, 32'd3, 4'd2, 4'd0, 1'b0, 1'b1);
    issue(4'd5, 32'd0, 32'd1, 4'd8, 4'd0, 1'b0, 1'b1);
    issue(4'd6, 32'd0, 32'd7, 4'd2, 4'd0, 1'b0, 1'b1);
    issue(4'd7, 32'd0, 32'd9, 4'd8, 4'd0, 1'b0, 1'b1);
    check("full_occ", 32'(occupancy), 4);
    check("full_not_ready", 32'(issue_ready), 0);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'd10;
    step();
    cdb_valid = 1'b0;
    check("multi_wake_no_ena", 32'(mul_ena), 0);
    step();
    check("sel0_ena", 32'(mul_ena), 1);
    check("sel0_b", mul_b, 32'd3);
    check("sel0_occ", 32'(occupancy), 3);
    wait_wb(lat);
    check("sel0_tag", 32'(wb_tag), 4);
    check("sel0_data", wb_data, 32'd30);
    grant();
    step();
    check("sel2_a", mul_a, 32'd10);
    check("sel2_b", mul_b, 32'd7);
    check("sel2_occ", 32'(occupancy), 2);
    wait_wb(lat);
    check("sel2_tag", 32'(wb_tag), 6);
    check("sel2_data", wb_data, 32'd70);
    grant();

    // flush in the middle of an op
    issue(4'd9, 32'd5, 32'd5, 4'd0, 4'd0, 1'b1, 1'b1);
    step();
    step();
    step();
    check("pre_flush_ena", 32'(mul_ena), 1);
    flush = 1'b1;
    #1;
    check("flush_not_ready", 32'(issue_ready), 0);
    step();
    flush = 1'b0;
    check("flush_pulse", 32'(mul_flush), 1);
    check("flush_ena", 32'(mul_ena), 0);
    check("flush_occ", 32'(occupancy), 0);
    check("flush_wb_req", 32'(wb_req), 0);
    step();
    check("flush_pulse_end", 32'(mul_flush), 0);
    issue(4'd10, 32'd7, 32'd6, 4'd0, 4'd0, 1'b1, 1'b1);
    step();
    check("post_flush_ena", 32'(mul_ena), 1);
    wait_wb(lat);
    check("post_flush_lat", 32'(lat), 7);
    check("post_flush_data", wb_data, 32'd42);
    check("post_flush_tag", 32'(wb_tag), 10);
    grant();

    // issue while the CDB broadcasts the missing operand
    issue_tag = 4'd11; issue_vj = 32'd3; issue_j_rdy = 1'b1; issue_qk = 4'd9; issue_k_rdy = 1'b0;
    issue_vk = 32'd0; issue_valid = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd11;
    #1;
`ifdef MUL_RS_BYPASS_EN
    check("byp_ready", 32'(issue_ready), 1);
    step();
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    check("byp_occ", 32'(occupancy), 1);
`else
    check("stall_ready", 32'(issue_ready), 0);
    step();
    cdb_valid = 1'b0;
    check("stall_occ", 32'(occupancy), 0);
    issue_vk = 32'd11; issue_k_rdy = 1'b1;
    step();
    issue_valid = 1'b0;
    check("stall_occ_next", 32'(occupancy), 1);
`endif
    step();
    check("byp_b", mul_b, 32'd11);
    wait_wb(lat);
    check("byp_data", wb_data, 32'd33);
    grant();

    // async reset between edges in the middle of an op
    issue(4'd1, 32'd2, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1);
    issue(4'd2, 32'd2, 32'd3, 4'd0, 4'd0, 1'b1, 1'b1);
    step();
    check("pre_rst_ena", 32'(mul_ena), 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ena", 32'(mul_ena), 0);
    check("arst_a", mul_a, 0);
    check("arst_b", mul_b, 0);
    check("arst_wb_req", 32'(wb_req), 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_mul_flush", 32'(mul_flush), 0);
    step();
    rst = 1'b0;
    step();
    check("arst_ready", 32'(issue_ready), 1);
    check("arst_idle", 32'(mul_ena), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
